mem_responder: RTL

- Memory-side responder for the memory BIST controller.
- Accepts read/write requests over a req/ack handshake and stores data in an internal single-port array.
- Returns read data after a programmable latency.
- Sits under top as the device-under-test that the BIST controller drives to produce fail/done.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_array.sv | 26 ++
 rtl/mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM encoding, counter width and default widths for the memory responder
package mem_pkg;

  // Default geometry, shared with the BIST controller.
  localparam int DATA_WIDTH_DEF = 4;
  localparam int AD_WIDTH_DEF   = 4;

  // Read-latency counter width; covers latencies 1..7.
  localparam int CNT_WIDTH = 3;

  // Responder FSM states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Counter preload for a given read latency.
  function automatic logic [CNT_WIDTH-1:0] latency_load(input int lat);
    return CNT_WIDTH'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port storage, synchronous write and combinational read, no reset
module mem_array
  import mem_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int ad_width   = AD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ad_width-1:0]   addr,
  input  logic [data_width-1:0] wdata,
  output logic [data_width-1:0] rd_word
);

  logic [data_width-1:0] mem [0:(1<<ad_width)-1];

  // Commit a write on the clock edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  assign rd_word = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - req/ack memory responder with programmable read latency; optional MEM_FAULT_INJECT_EN stuck-at-1 overlay
module mem_responder
  import mem_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int ad_width   = AD_WIDTH_DEF,
  parameter int rd_latency = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic                          we,
  input  logic [ad_width-1:0]           addr,
  input  logic [data_width-1:0]         wdata,
`ifdef MEM_FAULT_INJECT_EN
  input  logic [ad_width-1:0]           fault_addr,
  input  logic [$clog2(data_width)-1:0] fault_bit,
`endif
  output logic                          ack,
  output logic [data_width-1:0]         rdata,
  output logic                          busy
);

  localparam logic [CNT_WIDTH-1:0] LAT_LOAD = latency_load(rd_latency);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ad_width-1:0]   addr_q;
  logic [data_width-1:0] wdata_q;
  logic                  ack_d;
  logic [data_width-1:0] rdata_d;
  logic                  latch_en;
  logic                  wr_en;
  logic [data_width-1:0] rd_word;
  logic [data_width-1:0] rd_fault;

  // The array write happens on the edge that leaves WRITE, so a reset
  // during the WRITE cycle drops the write.
  assign wr_en = (state_q == S_WRITE);
  assign busy  = (state_q != S_IDLE);

  mem_array #(
    .data_width(data_width),
    .ad_width  (ad_width)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .addr   (addr_q),
    .wdata  (wdata_q),
    .rd_word(rd_word)
  );

`ifdef MEM_FAULT_INJECT_EN
  // Force the selected bit high on reads of the faulty word; storage is untouched.
  always_comb begin
    rd_fault = rd_word;
    if (addr_q == fault_addr) begin
      rd_fault[fault_bit] = 1'b1;
    end
  end
`else
  assign rd_fault = rd_word;
`endif

  // Next-state and next-output decode; requests outside IDLE are ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    rdata_d  = rdata;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          if (we) begin
            state_d = S_WRITE;
            ack_d   = 1'b1;
          end else begin
            state_d = S_RDWAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_RDWAIT: begin
        if (cnt_q == '0) begin
          rdata_d = rd_fault;
          ack_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and output registers; an outstanding transaction is abandoned on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack     <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack     <= ack_d;
      rdata   <= rdata_d;
    end
  end

  // Request capture; holds across the transaction so the array sees a stable address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch_en) begin
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

endmodule
